// File: rtl/lsu_fu_if.sv
// Bundle of the memory-FU issue lane, data-memory port and completion broadcast.
// slave = the load/store unit, master = the reservation station / memory / complete-stage side.
interface lsu_fu_if #(
  parameter int XLEN      = 32,
  parameter int PREG_BITS = 6,
  parameter int ROB_BITS  = 4
);
  // Issue: an instruction transfers on a rising edge where in_valid && fu_rdy.
  // Memory: dmem_req and its address/data/strobes are held until dmem_ack;
  // dmem_rdata is sampled only in that ack cycle.
  // Completion: cpl_valid is a one-cycle pulse with no back-pressure.
  logic                 in_valid;
  logic [ROB_BITS-1:0]  in_rob;
  logic [PREG_BITS-1:0] in_rd;
  logic [XLEN-1:0]      in_base;
  logic [XLEN-1:0]      in_store_data;
  logic [XLEN-1:0]      in_imm;
  logic [2:0]           in_funct3;
  logic                 in_mem_read;
  logic                 in_mem_write;
  logic                 in_reg_write;
  logic                 fu_rdy;

  logic                 dmem_req;
  logic                 dmem_we;
  logic [XLEN-1:0]      dmem_addr;
  logic [XLEN-1:0]      dmem_wdata;
  logic [3:0]           dmem_wstrb;
  logic [XLEN-1:0]      dmem_rdata;
  logic                 dmem_ack;

  logic                 cpl_valid;
  logic [ROB_BITS-1:0]  cpl_rob;
  logic [PREG_BITS-1:0] cpl_rd;
  logic                 cpl_reg_write;
  logic [XLEN-1:0]      cpl_data;
  logic                 cpl_exc;

  modport slave (
    input  in_valid, in_rob, in_rd, in_base, in_store_data, in_imm,
           in_funct3, in_mem_read, in_mem_write, in_reg_write,
           dmem_rdata, dmem_ack,
    output fu_rdy, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
           cpl_valid, cpl_rob, cpl_rd, cpl_reg_write, cpl_data, cpl_exc
  );

  modport master (
    output in_valid, in_rob, in_rd, in_base, in_store_data, in_imm,
           in_funct3, in_mem_read, in_mem_write, in_reg_write,
           dmem_rdata, dmem_ack,
    input  fu_rdy, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
           cpl_valid, cpl_rob, cpl_rd, cpl_reg_write, cpl_data, cpl_exc
  );
endinterface

// File: rtl/lsu_fu.sv
// Load/store functional unit for issue lane 2: effective address, one req/ack
// memory transaction, and a single-cycle registered completion.
module lsu_fu #(
  parameter int XLEN        = 32,
  parameter int PREG_BITS   = 6,
  parameter int ROB_BITS    = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  lsu_fu_if.slave    bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, CPL = 2'd2} state_t;

  state_t               state;
  logic [7:0]           wait_cnt;
  logic [ROB_BITS-1:0]  q_rob;
  logic [PREG_BITS-1:0] q_rd;
  logic [2:0]           q_funct3;
  logic [1:0]           q_off;
  logic                 q_load;
  logic                 q_reg_write;

  logic            accept;
  logic [XLEN-1:0] eff_addr;
  logic            rw_ok, f3_ok, misaligned, op_bad;
  logic [3:0]      base_strb;
  logic [XLEN-1:0] rd_shift, load_ext;

  assign bus.fu_rdy = ((state == IDLE) || (state == CPL)) && !reset;
  assign accept     = bus.in_valid && bus.fu_rdy;
  assign dbg_state  = state;

  always_comb begin
    eff_addr = bus.in_base + bus.in_imm;
    rw_ok    = bus.in_mem_read ^ bus.in_mem_write;
    case (bus.in_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = bus.in_mem_read;
      default:                f3_ok = 1'b0;
    endcase
    misaligned = ((bus.in_funct3[1:0] == 2'b01) && eff_addr[0]) ||
                 ((bus.in_funct3[1:0] == 2'b10) && (eff_addr[1:0] != 2'b00));
    op_bad = !rw_ok || !f3_ok || misaligned;
    case (bus.in_funct3[1:0])
      2'b00:   base_strb = 4'b0001;
      2'b01:   base_strb = 4'b0011;
      default: base_strb = 4'b1111;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend per the latched funct3.
  always_comb begin
    rd_shift = bus.dmem_rdata >> {q_off, 3'b000};
    case (q_funct3)
      3'b000:  load_ext = {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      q_rob             <= '0;
      q_rd              <= '0;
      q_funct3          <= '0;
      q_off             <= '0;
      q_load            <= 1'b0;
      q_reg_write       <= 1'b0;
      bus.dmem_req      <= 1'b0;
      bus.dmem_we       <= 1'b0;
      bus.dmem_addr     <= '0;
      bus.dmem_wdata    <= '0;
      bus.dmem_wstrb    <= '0;
      bus.cpl_valid     <= 1'b0;
      bus.cpl_rob       <= '0;
      bus.cpl_rd        <= '0;
      bus.cpl_reg_write <= 1'b0;
      bus.cpl_data      <= '0;
      bus.cpl_exc       <= 1'b0;
    end else begin
      case (state)
        IDLE, CPL: begin
          bus.cpl_valid <= 1'b0;
          state         <= IDLE;
          if (accept) begin
            if (op_bad) begin
              // Faulting ops skip memory and complete on the next cycle.
              state             <= CPL;
              bus.cpl_valid     <= 1'b1;
              bus.cpl_exc       <= 1'b1;
              bus.cpl_reg_write <= 1'b0;
              bus.cpl_data      <= '0;
              bus.cpl_rob       <= bus.in_rob;
              bus.cpl_rd        <= bus.in_rd;
            end else begin
              state          <= REQ;
              wait_cnt       <= '0;
              q_rob          <= bus.in_rob;
              q_rd           <= bus.in_rd;
              q_funct3       <= bus.in_funct3;
              q_off          <= eff_addr[1:0];
              q_load         <= bus.in_mem_read;
              q_reg_write    <= bus.in_reg_write;
              bus.dmem_req   <= 1'b1;
              bus.dmem_we    <= bus.in_mem_write;
              bus.dmem_addr  <= {eff_addr[XLEN-1:2], 2'b00};
              bus.dmem_wdata <= bus.in_mem_write ?
                                (bus.in_store_data << {eff_addr[1:0], 3'b000}) : '0;
              bus.dmem_wstrb <= bus.in_mem_write ? (base_strb << eff_addr[1:0]) : 4'b0000;
            end
          end
        end
        REQ: begin
          if (bus.dmem_ack || (wait_cnt == 8'(ACK_TIMEOUT - 1))) begin
            // Ack has priority over a timeout expiring in the same cycle.
            state             <= CPL;
            bus.dmem_req      <= 1'b0;
            bus.dmem_we       <= 1'b0;
            bus.dmem_wdata    <= '0;
            bus.dmem_wstrb    <= 4'b0000;
            bus.cpl_valid     <= 1'b1;
            bus.cpl_rob       <= q_rob;
            bus.cpl_rd        <= q_rd;
            bus.cpl_exc       <= !bus.dmem_ack;
            bus.cpl_reg_write <= bus.dmem_ack && q_load && q_reg_write;
            bus.cpl_data      <= (bus.dmem_ack && q_load) ? load_ext : '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_fu.sv
// Directed bench for lsu_fu: hand-computed vectors plus an in-order ROB
// completion scoreboard.
module tb_lsu_fu;
  localparam int XLEN        = 32;
  localparam int PREG_BITS   = 6;
  localparam int ROB_BITS    = 4;
  localparam int ACK_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [ROB_BITS-1:0] exp_q[$];

  lsu_fu_if #(.XLEN(XLEN), .PREG_BITS(PREG_BITS), .ROB_BITS(ROB_BITS)) bus();

  lsu_fu #(.XLEN(XLEN), .PREG_BITS(PREG_BITS), .ROB_BITS(ROB_BITS),
           .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drivers
  task automatic set_op(input logic [3:0] rob, input logic [5:0] rd,
                        input logic [31:0] base, input logic [31:0] imm,
                        input logic [31:0] sdata, input logic [2:0] f3,
                        input logic ld, input logic st, input logic regw);
    bus.in_rob        = rob;
    bus.in_rd         = rd;
    bus.in_base       = base;
    bus.in_imm        = imm;
    bus.in_store_data = sdata;
    bus.in_funct3     = f3;
    bus.in_mem_read   = ld;
    bus.in_mem_write  = st;
    bus.in_reg_write  = regw;
  endtask

  task automatic issue(input logic [3:0] rob, input logic [5:0] rd,
                       input logic [31:0] base, input logic [31:0] imm,
                       input logic [31:0] sdata, input logic [2:0] f3,
                       input logic ld, input logic st, input logic regw,
                       input logic track);
    check("issue_rdy", 32'(bus.fu_rdy), 32'd1);
    set_op(rob, rd, base, imm, sdata, f3, ld, st, regw);
    bus.in_valid = 1'b1;
    if (track) exp_q.push_back(rob);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_ack(input int delay, input logic [31:0] rdata);
    repeat (delay) tick();
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = rdata;
    tick();
    bus.dmem_ack   = 1'b0;
  endtask

  // scoreboard: completions must arrive in issue order, never unannounced
  always @(negedge clk) begin
    logic [ROB_BITS-1:0] r;
    if (!reset && bus.cpl_valid) begin
      check("cpl_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        check("cpl_rob", 32'(bus.cpl_rob), 32'(r));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
    set_op(4'd0, 6'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check("rst_fu_rdy", 32'(bus.fu_rdy), 32'd0);
    check("rst_req", 32'(bus.dmem_req), 32'd0);
    check("rst_cpl_valid", 32'(bus.cpl_valid), 32'd0);
    check("rst_cpl_data", bus.cpl_data, 32'd0);
    check("rst_wstrb", 32'(bus.dmem_wstrb), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_rel_rdy", 32'(bus.fu_rdy), 32'd1);
    tick();

    // SW 0x100+4
    issue(4'd1, 6'd5, 32'h100, 32'd4, 32'hDEADBEEF, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1);
    check("sw_req", 32'(bus.dmem_req), 32'd1);
    check("sw_we", 32'(bus.dmem_we), 32'd1);
    check("sw_addr", bus.dmem_addr, 32'h104);
    check("sw_wstrb", 32'(bus.dmem_wstrb), 32'hF);
    check("sw_wdata", bus.dmem_wdata, 32'hDEADBEEF);
    check("sw_busy", 32'(bus.fu_rdy), 32'd0);
    do_ack(0, 32'h0);
    check("sw_cpl", 32'(bus.cpl_valid), 32'd1);
    check("sw_regw", 32'(bus.cpl_reg_write), 32'd0);
    check("sw_exc", 32'(bus.cpl_exc), 32'd0);
    check("sw_data", bus.cpl_data, 32'd0);
    check("sw_req_drop", 32'(bus.dmem_req), 32'd0);
    check("sw_cpl_rdy", 32'(bus.fu_rdy), 32'd1);
    tick();

    // stray ack in IDLE
    bus.dmem_ack = 1'b1;
    tick();
    bus.dmem_ack = 1'b0;
    check("stray_cpl", 32'(bus.cpl_valid), 32'd0);
    check("stray_state", 32'(dbg_state), 32'd0);

    // LB / LBU / LH
    issue(4'd2, 6'd7, 32'h200, 32'd3, 32'd0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1);
    check("lb_addr", bus.dmem_addr, 32'h200);
    check("lb_we", 32'(bus.dmem_we), 32'd0);
    check("lb_wstrb", 32'(bus.dmem_wstrb), 32'd0);
    check("lb_wdata", bus.dmem_wdata, 32'd0);
    do_ack(0, 32'h80123456);
    check("lb_data", bus.cpl_data, 32'hFFFFFF80);
    check("lb_regw", 32'(bus.cpl_reg_write), 32'd1);
    check("lb_rd", 32'(bus.cpl_rd), 32'd7);
    tick();
    issue(4'd3, 6'd8, 32'h200, 32'd3, 32'd0, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1);
    do_ack(0, 32'h80123456);
    check("lbu_data", bus.cpl_data, 32'h00000080);
    check("lbu_rd", 32'(bus.cpl_rd), 32'd8);
    tick();
    issue(4'd10, 6'd9, 32'h200, 32'd2, 32'd0, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1);
    do_ack(0, 32'hBEEF0000);
    check("lh_data", bus.cpl_data, 32'hFFFFBEEF);
    tick();

    // SH to 0x302
    issue(4'd11, 6'd0, 32'h300, 32'd2, 32'h00001234, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1);
    check("sh_addr", bus.dmem_addr, 32'h300);
    check("sh_wstrb", 32'(bus.dmem_wstrb), 32'hC);
    check("sh_wdata", bus.dmem_wdata, 32'h12340000);
    do_ack(0, 32'h0);
    check("sh_cpl", 32'(bus.cpl_valid), 32'd1);
    check("sh_exc", 32'(bus.cpl_exc), 32'd0);
    tick();

    // misaligned LW and illegal ops
    issue(4'd12, 6'd3, 32'h300, 32'd1, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
    check("mis_req", 32'(bus.dmem_req), 32'd0);
    check("mis_cpl", 32'(bus.cpl_valid), 32'd1);
    check("mis_exc", 32'(bus.cpl_exc), 32'd1);
    check("mis_regw", 32'(bus.cpl_reg_write), 32'd0);
    check("mis_data", bus.cpl_data, 32'd0);
    check("mis_rd", 32'(bus.cpl_rd), 32'd3);
    tick();
    issue(4'd13, 6'd4, 32'h400, 32'd0, 32'd0, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1);
    check("both_exc", 32'(bus.cpl_exc), 32'd1);
    check("both_req", 32'(bus.dmem_req), 32'd0);
    tick();
    issue(4'd14, 6'd4, 32'h400, 32'd0, 32'd0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
    check("sbu_exc", 32'(bus.cpl_exc), 32'd1);
    tick();

    // back-to-back with in_valid held, 3-cycle ack delay
    set_op(4'd4, 6'd20, 32'h400, 32'd0, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1);
    bus.in_valid = 1'b1;
    exp_q.push_back(4'd4);
    tick();
    check("b2b_a_req", 32'(bus.dmem_req), 32'd1);
    check("b2b_a_addr", bus.dmem_addr, 32'h400);
    check("b2b_busy1", 32'(bus.fu_rdy), 32'd0);
    set_op(4'd5, 6'd21, 32'h400, 32'd4, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(4'd5);
    tick();
    check("b2b_busy2", 32'(bus.fu_rdy), 32'd0);
    tick();
    check("b2b_busy3", 32'(bus.fu_rdy), 32'd0);
    check("b2b_a_addr_hold", bus.dmem_addr, 32'h400);
    do_ack(0, 32'h11111111);
    check("b2b_a_cpl", 32'(bus.cpl_valid), 32'd1);
    check("b2b_a_data", bus.cpl_data, 32'h11111111);
    check("b2b_a_rd", 32'(bus.cpl_rd), 32'd20);
    check("b2b_cpl_rdy", 32'(bus.fu_rdy), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("b2b_b_req", 32'(bus.dmem_req), 32'd1);
    check("b2b_b_addr", bus.dmem_addr, 32'h404);
    check("b2b_b_nocpl", 32'(bus.cpl_valid), 32'd0);
    do_ack(2, 32'h22222222);
    check("b2b_b_cpl", 32'(bus.cpl_valid), 32'd1);
    check("b2b_b_data", bus.cpl_data, 32'h22222222);
    check("b2b_b_rd", 32'(bus.cpl_rd), 32'd21);
    tick();
    check("b2b_no_dup", 32'(bus.cpl_valid), 32'd0);
    check("b2b_idle", 32'(dbg_state), 32'd0);
    check("b2b_req_low", 32'(bus.dmem_req), 32'd0);

    // timeout: no ack
    issue(4'd6, 6'd1, 32'h500, 32'd0, 32'h0000AAAA, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1);
    cnt = 0;
    while (bus.dmem_req && cnt < 20) begin
      cnt++;
      tick();
    end
    check("to_req_cycles", 32'(cnt), 32'd4);
    check("to_cpl", 32'(bus.cpl_valid), 32'd1);
    check("to_exc", 32'(bus.cpl_exc), 32'd1);
    check("to_data", bus.cpl_data, 32'd0);
    check("to_regw", 32'(bus.cpl_reg_write), 32'd0);
    tick();

    // ack in the expiry cycle wins
    issue(4'd7, 6'd2, 32'h700, 32'd0, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
    do_ack(3, 32'h5A5A5A5A);
    check("tie_cpl", 32'(bus.cpl_valid), 32'd1);
    check("tie_exc", 32'(bus.cpl_exc), 32'd0);
    check("tie_data", bus.cpl_data, 32'h5A5A5A5A);
    tick();

    // reset during REQ abandons the op
    issue(4'd8, 6'd2, 32'h600, 32'd0, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0);
    check("rmid_req", 32'(bus.dmem_req), 32'd1);
    reset = 1'b1;
    tick();
    check("rmid_req_low", 32'(bus.dmem_req), 32'd0);
    check("rmid_cpl_low", 32'(bus.cpl_valid), 32'd0);
    check("rmid_rdy_low", 32'(bus.fu_rdy), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rmid_rdy_back", 32'(bus.fu_rdy), 32'd1);
    issue(4'd9, 6'd30, 32'h600, 32'd8, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
    check("rmid_lw_addr", bus.dmem_addr, 32'h608);
    do_ack(1, 32'hCAFEF00D);
    check("rmid_lw_cpl", 32'(bus.cpl_valid), 32'd1);
    check("rmid_lw_data", bus.cpl_data, 32'hCAFEF00D);
    check("rmid_lw_exc", 32'(bus.cpl_exc), 32'd0);
    check("rmid_lw_regw", 32'(bus.cpl_reg_write), 32'd1);
    tick();
    tick();

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lsu_fu.md
# lsu_fu

Load/store functional unit serving issue lane 2 (memory FU) of the reservation station. It accepts one issued memory instruction at a time and forms the effective address. It then runs a req/ack transaction on the data-memory port and broadcasts a single-cycle completion (ROB number, destination physical register, load data, exception flag) to the complete stage. Its `fu_rdy` output is the memory-FU ready signal the reservation station samples before driving lane 2.

## Interface
- `XLEN`, 32: data/address width.
- `PREG_BITS`, 6: physical register index width (64 physical registers).
- `ROB_BITS`, 4: ROB number width (16 entries).
- `ACK_TIMEOUT`, 64: cycles in REQ without `dmem_ack` before abort; legal range 2..255.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: issue lane 2 holds a valid instruction.
- `in_rob` in ROB_BITS: ROB number.
- `in_rd` in PREG_BITS: destination physical register.
- `in_base` in XLEN: rs1 data.
- `in_store_data` in XLEN: rs2 data.
- `in_imm` in XLEN: sign-extended offset.
- `in_funct3` in 3: access size/sign.
- `in_mem_read` in 1: load.
- `in_mem_write` in 1: store.
- `in_reg_write` in 1: RegWrite.
- `fu_rdy` out 1: unit can accept this cycle.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: write request.
- `dmem_addr` out XLEN: word-aligned address, [1:0]=0.
- `dmem_wdata` out XLEN: lane-shifted store data.
- `dmem_wstrb` out 4: byte enables.
- `dmem_rdata` in XLEN: read word, valid with ack.
- `dmem_ack` in 1: request done.
- `cpl_valid` out 1: completion pulse.
- `cpl_rob` out ROB_BITS: completed ROB number.
- `cpl_rd` out PREG_BITS: destination register.
- `cpl_reg_write` out 1: write `cpl_data` to `cpl_rd`.
- `cpl_data` out XLEN: extended load data, else 0.
- `cpl_exc` out 1: misaligned, illegal, or timeout.

## Operation
- FSM states: IDLE, REQ, CPL. Reset → IDLE.
- `fu_rdy` = (IDLE or CPL) and not `reset`.
- Accept on posedge with `in_valid && fu_rdy`. Latch all inputs, then compute `addr = in_base + in_imm` mod 2^XLEN.
- Legal funct3 values:
  - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- Misaligned cases: halfword with addr[0]=1; word with addr[1:0]≠0.
- Also illegal: both or neither of `in_mem_read`/`in_mem_write` set.
- Accept with an illegal or misaligned op → CPL directly. Set `cpl_exc`=1, `cpl_reg_write`=0, `cpl_data`=0. No memory access.
- Accept with a legal op → REQ.
- REQ: drive `dmem_req`=1, `dmem_addr`={addr[XLEN-1:2],2'b00}, `dmem_we`=mem_write. Hold all dmem outputs stable until ack.
- Store lane shift: `wdata` = store_data << (8*addr[1:0]). `wstrb` is 0001/0011/1111 << addr[1:0].
- Loads drive `wstrb`=0 and `wdata`=0.
- On `dmem_ack` in REQ → CPL. For a load, register the selected byte/half/word of `dmem_rdata`, sign- or zero-extended per funct3.
- CPL: `cpl_valid`=1 for exactly one cycle.
  - `cpl_reg_write` = latched reg_write AND load AND no exc.
  - For stores, `cpl_data`=0.
  - Next state: REQ or CPL if a new accept occurs this cycle, else IDLE.
- Timeout: a wait counter clears on entering REQ and increments each REQ cycle without ack. When it reaches ACK_TIMEOUT-1 with no ack → CPL with `cpl_exc`=1, `cpl_reg_write`=0. `dmem_req` drops.
- `dmem_ack` outside REQ is ignored.
- Reset mid-transaction abandons the op: `dmem_req` is low from the cycle after the reset edge, and no completion is issued.

## Timing
- Reset values: `fu_rdy`=0 while `reset` is high; every other output is 0.
- Load/store fast path:
  - Accept at edge N.
  - `dmem_req` high during cycle N+1.
  - Ack in cycle N+1 → `cpl_valid` in cycle N+2.
  - `fu_rdy` stays high in N+2, so the next accept can occur at edge N+2.
- Sustained throughput: one memory op per 2 cycles with zero-wait memory.
- Exception fast path: accept at N → `cpl_valid` in N+1.
- Each extra wait cycle before ack adds one cycle of latency.
- Ack and timeout expiry in the same cycle: the ack wins, giving a normal completion.
- Completion outputs are registered. `cpl_*` other than `cpl_valid` hold their last values when `cpl_valid`=0.

## Test plan
- SW: base 0x100, imm 4, data 0xDEADBEEF, ack in first REQ cycle → `dmem_addr`=0x104, `wstrb`=1111, `wdata`=0xDEADBEEF. `cpl_valid` 2 cycles after accept with `cpl_reg_write`=0, `cpl_exc`=0.
- LB/LBU at addr 0x203, rdata 0x80xxxxxx → `cpl_data`=0xFFFFFF80 for LB and 0x00000080 for LBU. `cpl_reg_write`=1, `cpl_rd`/`cpl_rob` equal the issued values.
- SH to 0x302, data 0x1234 → `wstrb`=1100, `wdata`=0x12340000. LW to 0x301 → no `dmem_req`, `cpl_exc`=1 one cycle after accept.
- Back-to-back: in_valid held across two ops with 3-cycle ack delay → `fu_rdy` low during REQ. Exactly two completions, ROB numbers in order, no duplicate accept.
- No ack with ACK_TIMEOUT=4 → `dmem_req` high for exactly 4 cycles, then `cpl_exc`=1, `cpl_data`=0.
- Reset asserted during REQ → `dmem_req` and `cpl_valid` are 0 from the next cycle, `fu_rdy` returns 1 after reset deasserts, and a following LW completes normally.
